// File: rtl/traffic_light.sv
// Two-road intersection controller: SN and EW cycle green -> yellow -> red in turn
// while EN is high, with a per-road countdown of remaining ticks in the current colour.
module traffic_light #(
  parameter int GREEN_TIME  = 9,
  parameter int YELLOW_TIME = 3,
  parameter int TICK_DIV    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  output logic [2:0] south_north_light,
  output logic [2:0] east_west_light,
  output logic [3:0] south_north_count,
  output logic [3:0] east_west_count
);

  localparam logic [3:0] G_T = 4'(GREEN_TIME);
  localparam logic [3:0] Y_T = 4'(YELLOW_TIME);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {ALL_RED, SN_G, SN_Y, EW_G, EW_Y} state_t;

  state_t          state, state_nx;
  logic [3:0]      timer, timer_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            tick;

  function automatic logic [2:0] sn_light(input state_t s);
    case (s)
      SN_G:    return GRN;
      SN_Y:    return YEL;
      default: return RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_light(input state_t s);
    case (s)
      EW_G:    return GRN;
      EW_Y:    return YEL;
      default: return RED;
    endcase
  endfunction

  // A red road waiting through the other road's green also has that road's yellow ahead.
  function automatic logic [3:0] sn_count(input state_t s, input logic [3:0] t);
    case (s)
      SN_G, SN_Y, EW_Y: return t;
      EW_G:             return t + Y_T;
      default:          return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] ew_count(input state_t s, input logic [3:0] t);
    case (s)
      EW_G, EW_Y, SN_Y: return t;
      SN_G:             return t + Y_T;
      default:          return 4'd0;
    endcase
  endfunction

  always_comb begin
    tick     = (cnt == CNT_LAST);
    state_nx = state;
    timer_nx = timer;
    cnt_nx   = tick ? '0 : cnt + CW'(1);
    if (!EN) begin
      state_nx = ALL_RED;
      timer_nx = 4'd0;
      cnt_nx   = '0;
    end else if (state == ALL_RED) begin
      state_nx = SN_G;
      timer_nx = G_T;
      cnt_nx   = '0;
    end else if (tick) begin
      if (timer > 4'd1) begin
        timer_nx = timer - 4'd1;
      end else begin
        case (state)
          SN_G:    begin state_nx = SN_Y; timer_nx = Y_T; end
          SN_Y:    begin state_nx = EW_G; timer_nx = G_T; end
          EW_G:    begin state_nx = EW_Y; timer_nx = Y_T; end
          default: begin state_nx = SN_G; timer_nx = G_T; end
        endcase
      end
    end
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= ALL_RED;
      timer             <= 4'd0;
      cnt               <= '0;
      south_north_light <= RED;
      east_west_light   <= RED;
      south_north_count <= 4'd0;
      east_west_count   <= 4'd0;
    end else begin
      state             <= state_nx;
      timer             <= timer_nx;
      cnt               <= cnt_nx;
      south_north_light <= sn_light(state_nx);
      east_west_light   <= ew_light(state_nx);
      south_north_count <= sn_count(state_nx, timer_nx);
      east_west_count   <= ew_count(state_nx, timer_nx);
    end
  end

endmodule

// File: tb/tb_traffic_light.sv
// Scoreboard bench for traffic_light: two instances (tick every cycle and every 2nd cycle)
// compared against a position-in-period model of the light sequence.
module tb_traffic_light;

  localparam int G = 9;
  localparam int Y = 3;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef struct packed {
    logic [2:0] sl;
    logic [2:0] el;
    logic [3:0] sc;
    logic [3:0] ec;
  } obs_t;

  logic clk;
  logic rst;
  logic EN;
  logic [2:0] sl1, el1, sl2, el2;
  logic [3:0] sc1, ec1, sc2, ec2;

  obs_t q1[$];
  obs_t q2[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  bit   run    = 0;
  int   k      = 0;

  traffic_light #(.GREEN_TIME(G), .YELLOW_TIME(Y), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .EN(EN),
    .south_north_light(sl1), .east_west_light(el1),
    .south_north_count(sc1), .east_west_count(ec1)
  );

  traffic_light #(.GREEN_TIME(G), .YELLOW_TIME(Y), .TICK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .EN(EN),
    .south_north_light(sl2), .east_west_light(el2),
    .south_north_count(sc2), .east_west_count(ec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs from the number of cycles k since the sequence (re)started.
  function automatic obs_t model(input bit r, input int kk, input int div);
    obs_t o;
    int per, p, q;
    o.sl = RED; o.el = RED; o.sc = 4'd0; o.ec = 4'd0;
    if (!r) return o;
    per = 2 * (G + Y);
    p = (kk / div) % per;
    if (p < G) begin
      o.sl = GRN; o.sc = 4'(G - p); o.ec = 4'(G + Y - p);
    end else if (p < G + Y) begin
      o.sl = YEL; o.sc = 4'(G + Y - p); o.ec = 4'(G + Y - p);
    end else if (p < 2 * G + Y) begin
      q = p - (G + Y);
      o.el = GRN; o.ec = 4'(G - q); o.sc = 4'(G + Y - q);
    end else begin
      o.el = YEL; o.sc = 4'(per - p); o.ec = 4'(per - p);
    end
    return o;
  endfunction

  task automatic step(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    EN  = e;
    if (!r || !e) run = 0;
    else if (!run) begin run = 1; k = 0; end
    else k++;
    q1.push_back(model(run, k, 1));
    q2.push_back(model(run, k, 2));
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got === exp && !(got.sl != RED && got.el != RED)) passed++;
    else $display("FAIL %s cycle %0d: got sn=%b ew=%b sc=%0d ec=%0d, want sn=%b ew=%b sc=%0d ec=%0d",
                  name, cyc, got.sl, got.el, got.sc, got.ec, exp.sl, exp.el, exp.sc, exp.ec);
  endtask

  // Monitor: the DUT presents a new output every cycle; pop one expectation per edge.
  always @(posedge clk) begin
    obs_t e1, e2;
    #1;
    cyc++;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("div1", {sl1, el1, sc1, ec1}, e1);
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      check("div2", {sl2, el2, sc2, ec2}, e2);
    end
  end

  initial begin
    rst = 1'b0;
    EN  = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 34; i++) step(1'b1, 1'b1);  // ends inside SN_Y
    step(1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1);  // ends inside EW_G
    step(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 19) != 0));
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    if (q1.size() != 0 || q2.size() != 0) begin
      total++;
      $display("FAIL drain: %0d/%0d expectations left, want 0/0", q1.size(), q2.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
